// File: rtl/radar_echo_emulator.sv
// Radar target emulator: echoes a trigger edge after ceil(dist/RANGE_PER_CYCLE) cycles (min 1), or gives no_return after the MAX_RANGE window.
// No backpressure: trigger edges that arrive while a pulse is in flight are dropped and reported on trigger_dropped.
module radar_echo_emulator #(
  parameter int unsigned RANGE_PER_CYCLE = 150,
  parameter int unsigned MAX_RANGE       = 300000,
  parameter int unsigned ECHO_WIDTH      = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        radar_pulse_trigger,
  input  logic        target_present,
  input  logic [31:0] target_distance,
  output logic        radar_echo,
  output logic        no_return,
  output logic        trigger_dropped,
  output logic        busy,
  output logic [15:0] echo_count,
  output logic [1:0]  emu_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ECHO  = 2'd2
  } state_t;

  localparam logic [31:0] RPC  = 32'(RANGE_PER_CYCLE);
  localparam logic [31:0] MAXR = 32'(MAX_RANGE);
  localparam logic [31:0] EW   = 32'(ECHO_WIDTH);

  state_t      state;
  logic        trig_prev;
  logic        trig_edge;
  logic        drop_pend;
  logic        hit;
  logic        new_hit;
  logic [31:0] acc;
  logic [31:0] dist_eff;
  logic [31:0] width_cnt;
  logic [32:0] acc_next;
  logic        reached;

  assign trig_edge = radar_pulse_trigger & ~trig_prev;
  assign new_hit   = target_present && (target_distance <= MAXR);

  // 33-bit sum so a distance near 2^32 can never wrap the comparison
  assign acc_next  = {1'b0, acc} + {1'b0, RPC};
  assign reached   = (acc_next >= {1'b0, dist_eff});

  assign emu_state = state;
  assign busy      = (state == COUNT) || (state == ECHO);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      trig_prev       <= 1'b0;
      drop_pend       <= 1'b0;
      hit             <= 1'b0;
      acc             <= '0;
      dist_eff        <= '0;
      width_cnt       <= '0;
      radar_echo      <= 1'b0;
      no_return       <= 1'b0;
      trigger_dropped <= 1'b0;
      echo_count      <= '0;
    end else begin
      trig_prev       <= radar_pulse_trigger;
      no_return       <= 1'b0;
      // Drop report is delayed one edge behind the ignored trigger edge
      drop_pend       <= trig_edge && ((state == COUNT) || (state == ECHO));
      trigger_dropped <= drop_pend;

      case (state)
        IDLE: begin
          radar_echo <= 1'b0;
          if (trig_edge) begin
            hit      <= new_hit;
            dist_eff <= new_hit ? target_distance : MAXR;
            acc      <= '0;
            state    <= COUNT;
          end
        end
        COUNT: begin
          if (reached) begin
            if (hit) begin
              state      <= ECHO;
              radar_echo <= 1'b1;
              echo_count <= echo_count + 16'd1;
              width_cnt  <= EW;
            end else begin
              state     <= IDLE;
              no_return <= 1'b1;
            end
          end else begin
            acc <= acc_next[31:0];
          end
        end
        ECHO: begin
          if (width_cnt <= 32'd1) begin
            radar_echo <= 1'b0;
            state      <= IDLE;
          end else begin
            width_cnt <= width_cnt - 32'd1;
          end
        end
        default: begin
          radar_echo <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radar_echo_emulator.sv
// Directed bench for radar_echo_emulator with default parameters (150 m/cycle, 300 km, width 1).
module tb_radar_echo_emulator;

  logic        CLK = 1'b0;
  logic        RST;
  logic        radar_pulse_trigger;
  logic        target_present;
  logic [31:0] target_distance;
  logic        radar_echo;
  logic        no_return;
  logic        trigger_dropped;
  logic        busy;
  logic [15:0] echo_count;
  logic [1:0]  emu_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_count    = 0;

  radar_echo_emulator dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .radar_pulse_trigger (radar_pulse_trigger),
    .target_present      (target_present),
    .target_distance     (target_distance),
    .radar_echo          (radar_echo),
    .no_return           (no_return),
    .trigger_dropped     (trigger_dropped),
    .busy                (busy),
    .echo_count          (echo_count),
    .emu_state           (emu_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Raises the trigger so the next posedge is P0, then drops it.
  task automatic fire(input logic [31:0] d, input logic p);
    target_distance     = d;
    target_present      = p;
    radar_pulse_trigger = 1'b1;
    tick();
    radar_pulse_trigger = 1'b0;
  endtask

  // Steps from P0 until the FSM is back in IDLE; cycle numbers are relative to P0.
  task automatic watch(input int limit, output int rise, output int width, output int nr,
                       output int drops, output int busy_cyc, output int rise_state);
    rise = -1; width = 0; nr = -1; drops = 0; busy_cyc = 0; rise_state = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (radar_echo) begin
        if (rise < 0) begin
          rise       = k;
          rise_state = int'(emu_state);
        end
        width++;
      end
      if (no_return) nr = k;
      if (trigger_dropped) drops++;
      if (busy) busy_cyc++;
      if (emu_state == 2'd0) break;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; radar_pulse_trigger = 1'b0; target_present = 1'b0; target_distance = '0;
    tick(); tick();
    tests_run++;
    if ({radar_echo, no_return, trigger_dropped, busy, echo_count, emu_state} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", {radar_echo, no_return, trigger_dropped, busy, echo_count, emu_state});
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic_echo();
    int rise, width, nr, drops, bc, rs;
    fire(32'd1500, 1'b1);
    tests_run++;
    if (emu_state !== 2'd1) begin tests_failed++; $display("FAIL basic_state_p0: got %0d expected 1", emu_state); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_p0: got %0d expected 1", busy); end
    watch(40, rise, width, nr, drops, bc, rs);
    exp_count++;
    tests_run++;
    if (rise !== 10) begin tests_failed++; $display("FAIL basic_rise: got %0d expected 10", rise); end
    tests_run++;
    if (width !== 1) begin tests_failed++; $display("FAIL basic_width: got %0d expected 1", width); end
    tests_run++;
    if (rs !== 2) begin tests_failed++; $display("FAIL basic_echo_state: got %0d expected 2", rs); end
    tests_run++;
    if (emu_state !== 2'd0) begin tests_failed++; $display("FAIL basic_final_state: got %0d expected 0", emu_state); end
    tests_run++;
    if (echo_count !== 16'(exp_count)) begin tests_failed++; $display("FAIL basic_count: got %0d expected %0d", echo_count, exp_count); end
  endtask

  task automatic test_latency();
    logic [31:0] dists [5] = '{32'd1501, 32'd1, 32'd0, 32'd150, 32'd151};
    int          exps  [5] = '{11, 1, 1, 1, 2};
    int rise, width, nr, drops, bc, rs;
    for (int i = 0; i < 5; i++) begin
      fire(dists[i], 1'b1);
      watch(40, rise, width, nr, drops, bc, rs);
      exp_count++;
      tests_run++;
      if (rise !== exps[i]) begin tests_failed++; $display("FAIL latency_dist%0d: got %0d expected %0d", dists[i], rise, exps[i]); end
      tests_run++;
      if (width !== 1) begin tests_failed++; $display("FAIL latency_width_dist%0d: got %0d expected 1", dists[i], width); end
    end
    tests_run++;
    if (echo_count !== 16'(exp_count)) begin tests_failed++; $display("FAIL latency_count: got %0d expected %0d", echo_count, exp_count); end
  endtask

  task automatic test_no_return();
    logic [31:0] dists [2] = '{32'd1500, 32'd300001};
    logic        pres  [2] = '{1'b0, 1'b1};
    int rise, width, nr, drops, bc, rs;
    for (int i = 0; i < 2; i++) begin
      fire(dists[i], pres[i]);
      watch(2100, rise, width, nr, drops, bc, rs);
      tests_run++;
      if (nr !== 2000) begin tests_failed++; $display("FAIL noret%0d_at: got %0d expected 2000", i, nr); end
      tests_run++;
      if (rise !== -1) begin tests_failed++; $display("FAIL noret%0d_echo: got %0d expected -1", i, rise); end
      tests_run++;
      if (bc !== 1999) begin tests_failed++; $display("FAIL noret%0d_busy: got %0d expected 1999", i, bc); end
      tick();
      tests_run++;
      if (no_return !== 1'b0) begin tests_failed++; $display("FAIL noret%0d_single: got %0d expected 0", i, no_return); end
    end
    fire(32'd300000, 1'b1);
    watch(2100, rise, width, nr, drops, bc, rs);
    exp_count++;
    tests_run++;
    if (rise !== 2000 || nr !== -1) begin tests_failed++; $display("FAIL maxrange_hit: got rise %0d nr %0d expected rise 2000 nr -1", rise, nr); end
    tests_run++;
    if (echo_count !== 16'(exp_count)) begin tests_failed++; $display("FAIL noret_count: got %0d expected %0d", echo_count, exp_count); end
  endtask

  task automatic test_dropped();
    fire(32'd1500, 1'b1);
    repeat (4) tick();
    radar_pulse_trigger = 1'b1;
    tick();
    tests_run++;
    if (trigger_dropped !== 1'b0 || emu_state !== 2'd1) begin tests_failed++; $display("FAIL drop_p5: got dropped %0d state %0d expected 0 1", trigger_dropped, emu_state); end
    radar_pulse_trigger = 1'b0;
    tick();
    tests_run++;
    if (trigger_dropped !== 1'b1) begin tests_failed++; $display("FAIL drop_p6: got %0d expected 1", trigger_dropped); end
    tick();
    tests_run++;
    if (trigger_dropped !== 1'b0) begin tests_failed++; $display("FAIL drop_p7: got %0d expected 0", trigger_dropped); end
    tick(); tick();
    tests_run++;
    if (radar_echo !== 1'b0) begin tests_failed++; $display("FAIL drop_p9_echo: got %0d expected 0", radar_echo); end
    tick();
    exp_count++;
    tests_run++;
    if (radar_echo !== 1'b1 || emu_state !== 2'd2) begin tests_failed++; $display("FAIL drop_p10_echo: got echo %0d state %0d expected 1 2", radar_echo, emu_state); end
    radar_pulse_trigger = 1'b1;
    tick();
    tests_run++;
    if (radar_echo !== 1'b0 || emu_state !== 2'd0) begin tests_failed++; $display("FAIL drop_lastecho: got echo %0d state %0d expected 0 0", radar_echo, emu_state); end
    tick();
    tests_run++;
    if (trigger_dropped !== 1'b1 || emu_state !== 2'd0) begin tests_failed++; $display("FAIL drop_lastecho_pulse: got dropped %0d state %0d expected 1 0", trigger_dropped, emu_state); end
    radar_pulse_trigger = 1'b0;
    tick();
    tests_run++;
    if (echo_count !== 16'(exp_count)) begin tests_failed++; $display("FAIL drop_count: got %0d expected %0d", echo_count, exp_count); end
  endtask

  task automatic test_held_trigger();
    int rises = 0, drops = 0, rise_at = -1;
    logic prev_echo = 1'b0;
    target_distance     = 32'd300;
    target_present      = 1'b1;
    radar_pulse_trigger = 1'b1;
    tick();
    target_distance = 32'd0;
    for (int k = 1; k < 50; k++) begin
      tick();
      if (radar_echo && !prev_echo) begin
        rises++;
        if (rise_at < 0) rise_at = k;
      end
      if (trigger_dropped) drops++;
      prev_echo = radar_echo;
    end
    radar_pulse_trigger = 1'b0;
    tick();
    exp_count++;
    tests_run++;
    if (rise_at !== 2) begin tests_failed++; $display("FAIL held_rise: got %0d expected 2", rise_at); end
    tests_run++;
    if (rises !== 1) begin tests_failed++; $display("FAIL held_echoes: got %0d expected 1", rises); end
    tests_run++;
    if (drops !== 0) begin tests_failed++; $display("FAIL held_drops: got %0d expected 0", drops); end
  endtask

  task automatic test_reset_mid();
    int echoes = 0;
    int rise, width, nr, drops, bc, rs;
    fire(32'd1500, 1'b1);
    repeat (3) tick();
    RST = 1'b1;
    tick();
    tests_run++;
    if ({radar_echo, no_return, trigger_dropped, busy, echo_count, emu_state} !== 22'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %h expected 0", {radar_echo, no_return, trigger_dropped, busy, echo_count, emu_state});
    end
    RST = 1'b0;
    exp_count = 0;
    for (int k = 5; k <= 14; k++) begin
      tick();
      if (radar_echo || busy) echoes++;
    end
    tests_run++;
    if (echoes !== 0) begin tests_failed++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", echoes); end
    fire(32'd1500, 1'b1);
    watch(40, rise, width, nr, drops, bc, rs);
    exp_count++;
    tests_run++;
    if (rise !== 10) begin tests_failed++; $display("FAIL midreset_fresh_rise: got %0d expected 10", rise); end
    tests_run++;
    if (echo_count !== 16'(exp_count)) begin tests_failed++; $display("FAIL midreset_count: got %0d expected %0d", echo_count, exp_count); end
  endtask

  task automatic test_count_wrap();
    logic [15:0] exps [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    int rise, width, nr, drops, bc, rs;
    force dut.echo_count = 16'hFFFD;
    tick();
    release dut.echo_count;
    tick();
    for (int i = 0; i < 3; i++) begin
      fire(32'd0, 1'b1);
      watch(10, rise, width, nr, drops, bc, rs);
      tests_run++;
      if (echo_count !== exps[i]) begin tests_failed++; $display("FAIL wrap_%0d: got %h expected %h", i, echo_count, exps[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_echo();
    test_latency();
    test_no_return();
    test_dropped();
    test_held_trigger();
    test_reset_mid();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/radar_echo_emulator.md
Name: radar_echo_emulator

Overview:
- Target-side counterpart of the ARTAU radar interface. It consumes radar_pulse_trigger and returns radar_echo after a round-trip delay derived from a programmable target distance.
- Used as a hardware-in-the-loop responder and as the ICMS bench stimulus source.
- Range is modelled by accumulating RANGE_PER_CYCLE metres per clock until the latched target distance is reached.
- A missing or out-of-range target produces a no_return pulse instead of an echo.

Parameters:
- RANGE_PER_CYCLE, 150, one-way metres covered per clock (1 us clock; light round trip).
- MAX_RANGE, 300000, metres. Distances above this, or an absent target, give no echo.
- ECHO_WIDTH, 1, radar_echo high time in cycles (>=1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- radar_pulse_trigger  input  1  pulse request from ARTAU; rising edge is significant.
- target_present  input  1  a target exists; sampled at the accepted trigger edge.
- target_distance  input  32  target distance in metres, unsigned; sampled at the accepted trigger edge.
- radar_echo  output  1  echo pulse back to ARTAU.
- no_return  output  1  one-cycle pulse when a miss window expires.
- trigger_dropped  output  1  one-cycle pulse when a trigger edge is ignored.
- busy  output  1  high whenever state != IDLE.
- echo_count  output  16  number of echoes issued; wraps 0xFFFF->0.
- emu_state  output  2  IDLE=0, COUNT=1, ECHO=2 (3 unused; decodes to IDLE).

Behaviour:
- Reset: when RST is sampled high, every output goes to 0. State goes to IDLE, the accumulator to 0, and the trigger-edge register to 0. Reset wins over all other events, including mid-COUNT and mid-ECHO.
- Edge detect: trig_prev is registered each cycle. A rising edge means radar_pulse_trigger=1 and trig_prev=0 at a posedge. A level held high yields exactly one edge.
- IDLE, edge at posedge P0:
  - Latch dist = target_distance.
  - Latch hit = target_present && (target_distance <= MAX_RANGE).
  - If hit=0, dist_eff = MAX_RANGE; otherwise dist_eff = dist.
  - acc <= 0; state <= COUNT.
- COUNT, each posedge:
  - Compare acc + RANGE_PER_CYCLE >= dist_eff in 33 bits (no overflow).
  - If true and hit=1: state <= ECHO, radar_echo <= 1, echo_count += 1, width counter loaded.
  - If true and hit=0: state <= IDLE, no_return <= 1 for one cycle.
  - Otherwise: acc <= acc + RANGE_PER_CYCLE.
- Latency: with N = max(1, ceil(dist_eff / RANGE_PER_CYCLE)), radar_echo (or no_return) rises at posedge P0+N. dist=0 gives N=1.
- ECHO: radar_echo stays high for exactly ECHO_WIDTH cycles. It falls at P0+N+ECHO_WIDTH, and state returns to IDLE on that same edge.
- Triggers outside IDLE: an edge seen in COUNT or ECHO, including the last ECHO cycle, is ignored, and trigger_dropped pulses one cycle on the following posedge. An edge is accepted only if state==IDLE at that posedge.
- Input stability: target_distance and target_present changes after P0 have no effect on the pulse in flight.
- Single-cycle outputs: no_return and trigger_dropped are single-cycle registered pulses. No output is combinational from an input.

Test Plan:
- RANGE_PER_CYCLE=150, present=1, dist=1500, trigger edge at P0 -> radar_echo high exactly at P0+10 for 1 cycle; echo_count=1; emu_state 0->1->2->0.
- dist=1501 -> echo at P0+11. dist=1 -> echo at P0+1. dist=0 -> echo at P0+1.
- present=0, dist=1500 -> no echo; no_return pulses at P0+2000; busy high P0..P0+1999. Repeat with present=1, dist=300001 -> same result.
- Second trigger edge at P0+5 during COUNT (dist=1500) -> trigger_dropped at P0+6; single echo at P0+10; echo_count increments by 1 only.
- Trigger held high for 50 cycles (dist=300) -> exactly one echo at P0+2, no trigger_dropped. Target_distance changed to 0 at P0+1 -> echo still at P0+2.
- RST asserted at P0+4 of a dist=1500 run -> at next posedge all outputs 0, state IDLE, no echo at P0+10. A new edge after reset starts a fresh measurement. Also run 65536 echoes -> echo_count wraps to 0.
